mix_cols: RTL and testbench
===========================

Name: mix_cols

Overview:
- Registered AES MixColumns stage for the AES-128 encryption datapath, placed between ShiftRows and AddRoundKey in each round except the last.
- Transforms a 128-bit state column by column using the GF(2^8) matrix multiply from FIPS-197.
- Produces one result per enabled input, one clock later, with a valid strobe.
- An optional parameter selects InvMixColumns for reuse in a decryption path.

Parameters:
- INVERSE, default 0: 0 selects MixColumns, matrix rows {02 03 01 01} rotated. 1 selects InvMixColumns, matrix rows {0e 0b 0d 09} rotated. Fixed at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- data_in  input  128  AES state; byte 0 = [127:120] ... byte 15 = [7:0]; column c = bytes 4c..4c+3, row 0 in the most significant byte of the column
- i_en  input  1  data_in valid; sampled on rising clk
- data_out  output  128  transformed state, same byte ordering as data_in
- o_en  output  1  data_out valid strobe

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): data_out=128'h0, o_en=0. Both are held while rst is high. The first capture is on the first rising edge after rst falls.
- Byte ordering: column c word = data_in[127-32c -: 32]. Row r byte = column word [31-8r -: 8].
- Per column, output row r = XOR over k of (M[r][k] • s[k]), where M is the selected matrix.
- GF(2^8) multiply uses the AES polynomial x^8+x^4+x^3+x+1:
  - xtime(b) = (b<<1) XOR (b[7] ? 8'h1b : 8'h00)
  - ×03 = xtime(b) XOR b
  - ×09, ×0b, ×0d, ×0e are built from repeated xtime plus XOR
- The whole combinational function is purely XOR/shift logic: no lookup RAM, no multi-cycle iteration.
- Latency is exactly 1 cycle. On a rising edge with i_en=1: data_out <= f(data_in) and o_en <= 1.
- On a rising edge with i_en=0: o_en <= 0, and data_out holds its last value.
- Throughput is 1 state per cycle. Back-to-back i_en pulses give back-to-back o_en, each data_out matching the input of the previous cycle.
- i_en held high with constant data_in: o_en stays high and data_out stays constant.
- i_en=X/Z is treated as don't-care only while rst=1.
- rst asserted mid-stream: outputs clear immediately, and any in-flight result is discarded.
- No backpressure. The consumer must capture data_out in the cycle o_en=1, or rely on data_out holding while i_en stays low.

Test Plan:
- Reset then i_en=1, data_in=128'hf69f2445df4f9b17ad2b417be66c3710 -> o_en=1 one edge later, data_out=128'h2cfaee30f8e08480064389704477d44a.
- data_in=128'hdb135345f20a225c01010101c6c6c6c6 -> data_out=128'h8e4da1bc9fdc589d01010101c6c6c6c6. Checks the xtime reduction, the all-01 column and the all-c6 column.
- data_in=128'h0, then all-ones 128'hffff...ff -> data_out=128'h0, then 128'hffff...ff. Back-to-back with i_en held high, o_en stays 1 for both.
- i_en pulse one cycle, then low 3 cycles -> o_en high exactly one cycle, data_out holds its value. Then assert rst asynchronously mid-cycle -> data_out=0 and o_en=0 before the next edge.
- INVERSE=1 instance: data_in=128'h2cfaee30f8e08480064389704477d44a -> data_out=128'hf69f2445df4f9b17ad2b417be66c3710 after 1 cycle.
- Random: 1000 random states through chained INVERSE=0 then INVERSE=1 instances -> output equals the input two cycles earlier.

Source files
------------

// File: rtl/mix_cols.sv
// AES MixColumns / InvMixColumns stage: one 128-bit state per enabled cycle, registered result.
// Pure XOR/xtime datapath with a single pipeline register.
module mix_cols #(
    parameter int unsigned INVERSE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         i_en,
    output logic [127:0] data_out,
    output logic         o_en
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned NUM_COL = STATE_W / COL_W;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] d0, d1, d2, d3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        d0 = xt(s0);
        d1 = xt(s1);
        d2 = xt(s2);
        d3 = xt(s3);
        return {d0 ^ (d1 ^ s1) ^ s2 ^ s3,
                s0 ^ d1 ^ (d2 ^ s2) ^ s3,
                s0 ^ s1 ^ d2 ^ (d3 ^ s3),
                (d0 ^ s0) ^ s1 ^ s2 ^ d3};
    endfunction

    // x9 = x8^x, xb = x8^x2^x, xd = x8^x4^x, xe = x8^x4^x2
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int k = 0; k < 4; k++) begin
            s[k]  = col[31-8*k -: 8];
            x2    = xt(s[k]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[k] = x8 ^ s[k];
            mb[k] = x8 ^ x2 ^ s[k];
            md[k] = x8 ^ x4 ^ s[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [STATE_W-1:0] mixed_c;

    always_comb begin
        mixed_c = '0;
        for (int c = 0; c < int'(NUM_COL); c++) begin
            if (INVERSE != 0)
                mixed_c[127-32*c -: 32] = mix_inv(data_in[127-32*c -: 32]);
            else
                mixed_c[127-32*c -: 32] = mix_fwd(data_in[127-32*c -: 32]);
        end
    end

    // Output register: data_out holds when no new state is presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            o_en     <= 1'b0;
        end else begin
            o_en <= i_en;
            if (i_en)
                data_out <= mixed_c;
        end
    end

endmodule

// File: tb/tb_mix_cols.sv
// Directed and chained-random checks of mix_cols in both directions.
module tb_mix_cols;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic         i_en;
    logic [127:0] data_out;
    logic         o_en;

    logic         chain;
    logic [127:0] inv_din_drv;
    logic         inv_en_drv;
    logic [127:0] inv_din;
    logic         inv_en;
    logic [127:0] inv_out;
    logic         inv_oen;

    int checks   = 0;
    int failures = 0;

    logic [127:0] hist [1000];

    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    assign inv_din = chain ? data_out : inv_din_drv;
    assign inv_en  = chain ? o_en     : inv_en_drv;

    mix_cols #(.INVERSE(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .i_en     (i_en),
        .data_out (data_out),
        .o_en     (o_en)
    );

    mix_cols #(.INVERSE(1)) dut_inv (
        .clk      (clk),
        .rst      (rst),
        .data_in  (inv_din),
        .i_en     (inv_en),
        .data_out (inv_out),
        .o_en     (inv_oen)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_en        = 1'b0;
        data_in     = '0;
        chain       = 1'b0;
        inv_din_drv = '0;
        inv_en_drv  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_data", data_out, '0);
        check("rst_oen", 128'(o_en), 128'h0);
        rst = 1'b0;

        // First vector, one-cycle latency
        data_in = 128'hf69f2445df4f9b17ad2b417be66c3710;
        i_en    = 1'b1;
        @(negedge clk);
        check("v1_oen", 128'(o_en), 128'h1);
        check("v1_data", data_out, 128'h2cfaee30f8e08480064389704477d44a);

        // Single pulse then hold for 3 idle cycles
        i_en    = 1'b0;
        data_in = 128'hdb135345f20a225c01010101c6c6c6c6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_oen", 128'(o_en), 128'h0);
            check("hold_data", data_out, 128'h2cfaee30f8e08480064389704477d44a);
        end

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", data_out, '0);
        check("async_rst_oen", 128'(o_en), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // xtime reduction, all-01 and all-c6 columns
        data_in = 128'hdb135345f20a225c01010101c6c6c6c6;
        i_en    = 1'b1;
        @(negedge clk);
        check("v2_oen", 128'(o_en), 128'h1);
        check("v2_data", data_out, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);

        // Back-to-back zero then all-ones, then all-ones held
        data_in = '0;
        @(negedge clk);
        check("zero_oen", 128'(o_en), 128'h1);
        check("zero_data", data_out, '0);
        data_in = ONES;
        @(negedge clk);
        check("ones_oen", 128'(o_en), 128'h1);
        check("ones_data", data_out, ONES);
        @(negedge clk);
        check("ones_held_oen", 128'(o_en), 128'h1);
        check("ones_held_data", data_out, ONES);
        i_en = 1'b0;

        // Inverse instance directed vector
        inv_din_drv = 128'h2cfaee30f8e08480064389704477d44a;
        inv_en_drv  = 1'b1;
        @(negedge clk);
        check("inv_oen", 128'(inv_oen), 128'h1);
        check("inv_data", inv_out, 128'hf69f2445df4f9b17ad2b417be66c3710);
        inv_en_drv = 1'b0;
        @(negedge clk);
        check("inv_idle_oen", 128'(inv_oen), 128'h0);

        // Forward then inverse chain must reproduce input two cycles later
        chain = 1'b1;
        for (int i = 0; i < 1000; i++)
            hist[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 1002; i++) begin
            if (i >= 2) begin
                check("chain_oen", 128'(inv_oen), 128'h1);
                check("chain_data", inv_out, hist[i-2]);
            end
            if (i < 1000) begin
                data_in = hist[i];
                i_en    = 1'b1;
            end else begin
                i_en = 1'b0;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
